// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-client read bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  ownership FSM encoding (IDLE=0, OWN0=1, OWN1=2)
//   CLIENT0/1    client identifiers; these are the values stored in the
//                route FIFO, so each response can find its originator.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Client 0 is the imap BIU, client 1 is the weight BIU.
    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/arb_route_fifo.sv
// Route FIFO: remembers which client issued each outstanding memory read.
// Latency: head is available the cycle after the push (registered storage).
// Backpressure: full/empty flags; push when full and pop when empty are ignored.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_dat      write one client ID
//   pop                 discard the head entry
//   head                client ID of the oldest outstanding read
//   full, empty         occupancy flags
module arb_route_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_dat,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          slots [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_dat;
        end
    end

    assign head  = slots[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/bus_arbiter.sv
// Two-client read bus arbiter: one client owns the request path at a time, responses are routed back in issue order.
// Latency: 0 cycles on both request and response paths (combinational pass-through).
// Backpressure: owner rdy follows mem_rdy and route FIFO space; mem_rrdy follows the routed client's rrdy.
//
// Build option: define BUS_ARB_RR_EN for round-robin on simultaneous requests;
// without it client 0 has fixed priority and no last-served state exists.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cN_req                          bus ownership request, held for the transfer
//   cN_addr / cN_vld / cN_rdy       client read-address channel
//   cN_rdata / cN_rvld / cN_rrdy    client response channel
//   mem_addr / mem_vld / mem_rdy    memory read-address channel
//   mem_rdata / mem_rvld / mem_rrdy memory response channel (in order)
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ROUTE_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          c0_req,
    input  logic [AW-1:0] c0_addr,
    input  logic          c0_vld,
    output logic          c0_rdy,
    output logic [DW-1:0] c0_rdata,
    output logic          c0_rvld,
    input  logic          c0_rrdy,

    input  logic          c1_req,
    input  logic [AW-1:0] c1_addr,
    input  logic          c1_vld,
    output logic          c1_rdy,
    output logic [DW-1:0] c1_rdata,
    output logic          c1_rvld,
    input  logic          c1_rrdy,

    output logic [AW-1:0] mem_addr,
    output logic          mem_vld,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rvld,
    output logic          mem_rrdy
);

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    arb_state_t state;
    logic       own0;          // registered one-hot view of OWN0
    logic       own1;          // registered one-hot view of OWN1
    logic       grant_vld;
    logic       grant_id;

`ifdef BUS_ARB_RR_EN
    logic       last_served;
`endif

    // Grant decision used only while IDLE.
    always_comb begin
        grant_vld = c0_req | c1_req;
        grant_id  = CLIENT0;
        if (c0_req && c1_req) begin
`ifdef BUS_ARB_RR_EN
            // Alternate between clients when both ask at once.
            grant_id = (last_served == CLIENT1) ? CLIENT0 : CLIENT1;
`else
            grant_id = CLIENT0;
`endif
        end else if (c1_req) begin
            grant_id = CLIENT1;
        end
    end

    // Release does not wait for outstanding responses: the route FIFO
    // keeps track of who each in-flight read belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            own0  <= 1'b0;
            own1  <= 1'b0;
`ifdef BUS_ARB_RR_EN
            last_served <= CLIENT1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state <= (grant_id == CLIENT1) ? OWN1 : OWN0;
                        own0  <= (grant_id == CLIENT0);
                        own1  <= (grant_id == CLIENT1);
`ifdef BUS_ARB_RR_EN
                        last_served <= grant_id;
`endif
                    end
                end
                OWN0: begin
                    if (!c0_req) begin
                        state <= IDLE;
                        own0  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!c1_req) begin
                        state <= IDLE;
                        own1  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    own0  <= 1'b0;
                    own1  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Route FIFO
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic route_head;
    logic push;
    logic push_id;
    logic pop;

    arb_route_fifo #(
        .DEPTH (ROUTE_DEPTH)
    ) u_route_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_id),
        .pop      (pop),
        .head     (route_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    // Gating with rst_n keeps every handshake output low while reset is
    // asserted, including the first cycle before the FSM has been cleared.
    logic req_open;

    assign req_open = rst_n & ~fifo_full;

    assign mem_addr = own1 ? c1_addr : (own0 ? c0_addr : '0);
    assign mem_vld  = req_open & ((own0 & c0_vld) | (own1 & c1_vld));
    assign c0_rdy   = req_open & own0 & mem_rdy;
    assign c1_rdy   = req_open & own1 & mem_rdy;

    assign push     = mem_vld & mem_rdy;
    assign push_id  = own1 ? CLIENT1 : CLIENT0;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    // A response arriving with nothing outstanding belongs to nobody and
    // is left unacknowledged.
    logic rsp_open;
    logic c0_sel;
    logic c1_sel;

    assign rsp_open = rst_n & ~fifo_empty;
    assign c0_sel   = rsp_open & (route_head == CLIENT0);
    assign c1_sel   = rsp_open & (route_head == CLIENT1);

    assign c0_rdata = mem_rdata;
    assign c1_rdata = mem_rdata;
    assign c0_rvld  = c0_sel & mem_rvld;
    assign c1_rvld  = c1_sel & mem_rvld;
    assign mem_rrdy = (c0_sel & c0_rrdy) | (c1_sel & c1_rrdy);

    assign pop      = mem_rvld & mem_rrdy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          c0_req, c1_req;
    logic [AW-1:0] c0_addr, c1_addr;
    logic          c0_vld, c1_vld;
    logic          c0_rdy, c1_rdy;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          c0_rvld, c1_rvld;
    logic          c0_rrdy, c1_rrdy;
    logic [AW-1:0] mem_addr;
    logic          mem_vld, mem_rdy;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvld, mem_rrdy;

    bus_arbiter #(.AW(AW), .DW(DW), .ROUTE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_vld(c0_vld), .c0_rdy(c0_rdy),
        .c0_rdata(c0_rdata), .c0_rvld(c0_rvld), .c0_rrdy(c0_rrdy),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_vld(c1_vld), .c1_rdy(c1_rdy),
        .c1_rdata(c1_rdata), .c1_rvld(c1_rvld), .c1_rrdy(c1_rrdy),
        .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_rdy(mem_rdy),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld), .mem_rrdy(mem_rrdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Memory responder (auto mode) state
    bit            mem_auto;
    logic          mem_rdy_cfg;
    int            lat;
    logic [DW-1:0] mq_d[$];
    int            mq_t[$];

    // Observations
    int            hs_cnt;
    int            got_id[$];
    logic [DW-1:0] got_dat[$];
    logic [5:0]    smp;   // {mem_vld,c0_rdy,c1_rdy,mem_rrdy,c0_rvld,c1_rvld}
    logic          acc0, acc1;

    // Reference model: owner as -1/0/1, outstanding routes as a queue
    int   m_owner = -1;
    int   m_last  = 1;
    int   m_routes[$];
    logic m_push, m_pop;

    typedef struct packed {
        logic [7:0] stim;  // c0_req,c1_req,c0_vld,c1_vld,mem_rdy,mem_rvld,c0_rrdy,c1_rrdy
        logic [5:0] exp;   // mem_vld,c0_rdy,c1_rdy,mem_rrdy,c0_rvld,c1_rvld
    } vec_t;
    vec_t tbl [9];

    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        return DW'(a) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic full, empty;
        int   head;
        logic e_mvld, e_r0, e_r1, e_rrdy, e_v0, e_v1;
        full  = (m_routes.size() >= DEPTH);
        empty = (m_routes.size() == 0);
        head  = empty ? 0 : m_routes[0];
        e_mvld = 0; e_r0 = 0; e_r1 = 0; e_rrdy = 0; e_v0 = 0; e_v1 = 0;
        if (rst_n) begin
            e_mvld = ((m_owner == 0 && c0_vld) || (m_owner == 1 && c1_vld)) && !full;
            e_r0   = (m_owner == 0) && mem_rdy && !full;
            e_r1   = (m_owner == 1) && mem_rdy && !full;
            e_v0   = mem_rvld && !empty && head == 0;
            e_v1   = mem_rvld && !empty && head == 1;
            e_rrdy = !empty && (head == 0 ? c0_rrdy : c1_rrdy);
        end
        m_push = e_mvld && mem_rdy;
        m_pop  = mem_rvld && e_rrdy;
        chk("handshake_outputs", 64'({mem_vld, c0_rdy, c1_rdy, mem_rrdy, c0_rvld, c1_rvld}),
            64'({e_mvld, e_r0, e_r1, e_rrdy, e_v0, e_v1}));
        if (e_mvld)
            chk("mem_addr", 64'(mem_addr), 64'((m_owner == 1) ? c1_addr : c0_addr));
        if (e_v0) chk("c0_rdata", 64'(c0_rdata), 64'(mem_rdata));
        if (e_v1) chk("c1_rdata", 64'(c1_rdata), 64'(mem_rdata));
    endtask

    task automatic model_update();
        int g;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 1;
            m_routes.delete();
        end else begin
            if (m_pop)  void'(m_routes.pop_front());
            if (m_push) m_routes.push_back(m_owner);
            if (m_owner < 0) begin
                g = -1;
                if (c0_req && c1_req) begin
`ifdef BUS_ARB_RR_EN
                    g = 1 - m_last;
`else
                    g = 0;
`endif
                end else if (c0_req) g = 0;
                else if (c1_req)     g = 1;
                if (g >= 0) begin
                    m_owner = g;
                    m_last  = g;
                end
            end else if ((m_owner == 0 && !c0_req) || (m_owner == 1 && !c1_req)) begin
                m_owner = -1;
            end
        end
    endtask

    // One clock: inputs already driven after the previous edge.
    task automatic cycle();
        if (mem_auto) begin
            mem_rdy = mem_rdy_cfg;
            if (mq_d.size() > 0 && mq_t[0] <= cyc) begin
                mem_rvld  = 1'b1;
                mem_rdata = mq_d[0];
            end else begin
                mem_rvld  = 1'b0;
                mem_rdata = '0;
            end
        end
        @(negedge clk);
        check_outputs();
        smp  = {mem_vld, c0_rdy, c1_rdy, mem_rrdy, c0_rvld, c1_rvld};
        acc0 = c0_vld && c0_rdy;
        acc1 = c1_vld && c1_rdy;
        if (mem_vld && mem_rdy) begin
            hs_cnt++;
            if (mem_auto) begin
                mq_d.push_back(fdata(mem_addr));
                mq_t.push_back(cyc + lat);
            end
        end
        if (mem_auto && mem_rvld && mem_rrdy && mq_d.size() > 0) begin
            void'(mq_d.pop_front());
            void'(mq_t.pop_front());
        end
        if (c0_rvld && c0_rrdy) begin got_id.push_back(0); got_dat.push_back(c0_rdata); end
        if (c1_rvld && c1_rrdy) begin got_id.push_back(1); got_dat.push_back(c1_rdata); end
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        c0_req = 0; c1_req = 0; c0_vld = 0; c1_vld = 0;
        c0_addr = '0; c1_addr = '0; c0_rrdy = 1; c1_rrdy = 1;
        mem_rdy = 0; mem_rvld = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_auto = 0;
        rst_n = 0;
        repeat (2) cycle();
        rst_n = 1;
        mq_d.delete(); mq_t.delete();
        got_id.delete(); got_dat.delete();
        hs_cnt = 0;
    endtask

    task automatic issue(input int cl, input logic [AW-1:0] base, input int n);
        int k = 0;
        int guard = 0;
        if (cl == 0) c0_req = 1; else c1_req = 1;
        while (k < n && guard < 100) begin
            if (cl == 0) begin c0_vld = 1; c0_addr = base + AW'(4 * k); end
            else         begin c1_vld = 1; c1_addr = base + AW'(4 * k); end
            cycle();
            if ((cl == 0) ? acc0 : acc1) k++;
            guard++;
        end
        if (cl == 0) c0_vld = 0; else c1_vld = 0;
        if (k < n) chk("issue_timeout", 64'(k), 64'(n));
    endtask

    task automatic wait_resp(input int n);
        int guard = 0;
        while (got_id.size() < n && guard < 200) begin
            cycle();
            guard++;
        end
        if (got_id.size() < n) chk("resp_timeout", 64'(got_id.size()), 64'(n));
    endtask

    initial begin
        // Vector table starting from reset, one row per cycle.
        tbl[0] = '{8'b1010_1000, 6'b000000}; // c0 asks in IDLE: nothing yet
        tbl[1] = '{8'b1010_1000, 6'b110000}; // OWN0: request passes, push c0
        tbl[2] = '{8'b1010_0110, 6'b100110}; // mem stalls, response to c0, pop
        tbl[3] = '{8'b0101_1111, 6'b010000}; // c0 drops req, still owner; stray rvld ignored
        tbl[4] = '{8'b0101_1000, 6'b000000}; // IDLE
        tbl[5] = '{8'b0101_1000, 6'b101000}; // OWN1: push c1
        tbl[6] = '{8'b0100_1110, 6'b001001}; // c1 response held off by c1_rrdy=0
        tbl[7] = '{8'b0100_1111, 6'b001101}; // delivered, pop
        tbl[8] = '{8'b0100_1111, 6'b001000}; // FIFO empty: rvld ignored

        idle_inputs();
        mem_auto = 0; mem_rdy_cfg = 1; lat = 3; hs_cnt = 0;

        // Reset with active inputs: all handshake outputs must stay low.
        rst_n = 0;
        c0_req = 1; c0_vld = 1; c1_req = 1; c1_vld = 1;
        mem_rdy = 1; mem_rvld = 1;
        @(posedge clk); #1;
        repeat (2) begin
            cycle();
            chk("reset_outputs", 64'(smp), 64'd0);
        end
        chk("reset_state", 64'(dut.state), 64'(IDLE));

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 9; i++) begin
            {c0_req, c1_req, c0_vld, c1_vld, mem_rdy, mem_rvld, c0_rrdy, c1_rrdy} = tbl[i].stim;
            c0_addr = 32'h100 + AW'(i); c1_addr = 32'h200 + AW'(i);
            mem_rdata = 32'hA000 + DW'(i);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                64'({mem_vld, c0_rdy, c1_rdy, mem_rrdy, c0_rvld, c1_rvld}), 64'(tbl[i].exp));
            @(posedge clk); #1;
        end

        // Single owner, memory latency 3
        do_reset();
        mem_auto = 1; mem_rdy_cfg = 1; lat = 3;
        issue(0, 32'h1000, 4);
        wait_resp(4);
        c0_req = 0;
        cycle();
        chk("single_hs", 64'(hs_cnt), 64'd4);
        chk("single_nresp", 64'(got_id.size()), 64'd4);
        for (int i = 0; i < got_id.size() && i < 4; i++) begin
            chk($sformatf("single_id%0d", i), 64'(got_id[i]), 64'd0);
            chk($sformatf("single_dat%0d", i), 64'(got_dat[i]), 64'(fdata(32'h1000 + AW'(4 * i))));
        end

        // Contention
        do_reset();
        mem_rdy = 1;
        c0_req = 1; c1_req = 1;
        cycle();
        c0_req = 0;
        cycle();
        chk("contend_first", 64'(smp[4:3]), 64'b10);
        c0_req = 1;
        cycle();
        cycle();
`ifdef BUS_ARB_RR_EN
        chk("contend_second", 64'(smp[4:3]), 64'b01);
`else
        chk("contend_second", 64'(smp[4:3]), 64'b10);
`endif

        // Handover with outstanding responses
        do_reset();
        mem_auto = 1; mem_rdy_cfg = 1; lat = 30;
        issue(0, 32'h2000, 3);
        c0_req = 0;
        issue(1, 32'h3000, 2);
        c1_req = 0;
        wait_resp(5);
        chk("handover_nresp", 64'(got_id.size()), 64'd5);
        for (int i = 0; i < got_id.size() && i < 5; i++) begin
            chk($sformatf("handover_id%0d", i), 64'(got_id[i]), (i < 3) ? 64'd0 : 64'd1);
            chk($sformatf("handover_dat%0d", i), 64'(got_dat[i]),
                64'(fdata((i < 3) ? 32'h2000 + AW'(4 * i) : 32'h3000 + AW'(4 * (i - 3)))));
        end

        // FIFO full
        do_reset();
        mem_rdy = 1;
        c0_req = 1; c0_vld = 1; c0_addr = 32'h6000;
        repeat (14) cycle();
        chk("full_hs", 64'(hs_cnt), 64'd8);
        chk("full_blocked", 64'(smp[5:4]), 64'd0);
        mem_rvld = 1; c0_rrdy = 1;
        cycle();
        chk("full_pop", 64'(smp[2]), 64'd1);
        mem_rvld = 0;
        repeat (5) cycle();
        chk("full_one_more", 64'(hs_cnt), 64'd9);
        chk("full_reblocked", 64'(smp[5:4]), 64'd0);

        // Response backpressure
        do_reset();
        mem_rdy = 1;
        issue(0, 32'h4000, 1);
        mem_rdy = 0; mem_rvld = 1; mem_rdata = 32'hCAFE_F00D; c0_rrdy = 0;
        repeat (5) begin
            cycle();
            chk("bp_rrdy_low", 64'(smp[2]), 64'd0);
        end
        chk("bp_no_delivery", 64'(got_id.size()), 64'd0);
        c0_rrdy = 1;
        cycle();
        chk("bp_delivered", 64'(got_id.size()), 64'd1);
        if (got_dat.size() > 0) chk("bp_data", 64'(got_dat[0]), 64'h0000_0000_CAFE_F00D);
        mem_rvld = 0;

        // Reset with four outstanding
        do_reset();
        mem_rdy = 1;
        issue(0, 32'h5000, 4);
        rst_n = 0;
        cycle();
        rst_n = 1; c0_req = 0; c0_vld = 0;
        chk("rst_mid_state", 64'(dut.state), 64'(IDLE));
        mem_rvld = 1; c0_rrdy = 1; c1_rrdy = 1;
        cycle();
        chk("rst_mid_stray", 64'(smp[2:0]), 64'd0);
        mem_rvld = 0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) c0_req = ~c0_req;
            if ($urandom_range(0, 5) == 0) c1_req = ~c1_req;
            c0_vld    = $urandom_range(0, 1);
            c1_vld    = $urandom_range(0, 1);
            c0_addr   = $urandom;
            c1_addr   = $urandom;
            mem_rdy   = ($urandom_range(0, 3) != 0);
            mem_rvld  = $urandom_range(0, 1);
            mem_rdata = $urandom;
            c0_rrdy   = ($urandom_range(0, 3) != 0);
            c1_rrdy   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
